param_counter: RTL and testbench

- Parametrised successor to the team's fixed 3-bit free-running counter.
- Features: generic WIDTH, up/down direction, programmable terminal value (modulo), wrap or saturate mode, synchronous clear/load, built-in clock-enable prescaler, terminal-count pulse and sticky overflow flag.
- Used as the general-purpose timer/event counter primitive inside larger control blocks.

---
 rtl/counter_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 44 ++++
 rtl/param_counter.sv | 112 +++++++++++
 tb/tb_param_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the parametrised counter primitive: direction and boundary-mode encodings.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_e;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_rst,
    output logic tick
);

    if (PRESCALE <= 1) begin : g_passthru
        // No divider state needed; clock/reset/sync_rst are intentionally unused here.
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, sync_rst};
        assign tick      = en;
    end else begin : g_div
        localparam int unsigned PW = $clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] pre_q;
        logic [PW-1:0] pre_d;

        assign tick = en && (pre_q == LAST);

        always_comb begin
            pre_d = pre_q;
            if (sync_rst) begin
                pre_d = '0;
            end else if (en) begin
                pre_d = tick ? '0 : pre_q + PW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_d;
            end
        end
    end

endmodule : tick_prescaler

// File: rtl/param_counter.sv
// General-purpose up/down counter with programmable terminal value, wrap/saturate,
// clear/load, prescaled stepping, terminal-count pulse and sticky boundary flag.
module param_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 2) begin : g_chk_width
        $error("param_counter: WIDTH must be >= 2");
    end
    if (PRESCALE < 1) begin : g_chk_prescale
        $error("param_counter: PRESCALE must be >= 1");
    end
    if ((WIDTH < 64) && (64'(RESET_VAL) >= (64'd1 << WIDTH))) begin : g_chk_reset_val
        $error("param_counter: RESET_VAL does not fit in WIDTH bits");
    end

    logic             tick_c;
    logic             up_c;
    logic             sat_c;
    logic             hit_c;
    logic [WIDTH-1:0] stepped_c;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_rst (clr | load),
        .tick     (tick_c)
    );

    assign up_c  = (cnt_dir_e'(dir) == DIR_UP);
    assign sat_c = (cnt_mode_e'(mode) == CNT_SAT);

    // Up boundary uses >= so a loaded value above max_val still wraps/saturates.
    assign hit_c = up_c ? (count_q >= max_val) : (count_q == '0);

    always_comb begin
        stepped_c = count_q;
        if (up_c) begin
            if (hit_c) begin
                stepped_c = sat_c ? max_val : '0;
            end else begin
                stepped_c = count_q + WIDTH'(1);
            end
        end else begin
            if (hit_c) begin
                stepped_c = sat_c ? '0 : max_val;
            end else begin
                stepped_c = count_q - WIDTH'(1);
            end
        end
    end

    // Priority: clr > load > step; tc is a one-edge pulse.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_val;
        end else if (tick_c) begin
            count_d = stepped_c;
            tc_d    = hit_c;
            if (hit_c) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= WIDTH'(RESET_VAL);
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule : param_counter

// File: tb/tb_param_counter.sv
// Bench for param_counter: two instances (PRESCALE=1/RESET_VAL=3 and PRESCALE=4/RESET_VAL=0)
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_param_counter;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         dir;
    logic         mode;
    logic [W-1:0] max_val;

    logic [W-1:0] cnt_a, cnt_b;
    logic         tc_a, tc_b, ovf_a, ovf_b;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 0;

    param_counter #(.WIDTH(W), .PRESCALE(1), .RESET_VAL(3)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .mode(mode), .max_val(max_val), .count(cnt_a), .tc(tc_a), .ovf(ovf_a)
    );

    param_counter #(.WIDTH(W), .PRESCALE(4), .RESET_VAL(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .mode(mode), .max_val(max_val), .count(cnt_b), .tc(tc_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one entry per instance.
    int           ps [2] = '{1, 4};
    int           rv [2] = '{3, 0};
    int           m_pre [2];
    logic [W-1:0] m_cnt [2];
    logic         m_tc  [2];
    logic         m_ovf [2];

    function automatic logic at_bound(logic [W-1:0] c, logic up, logic [W-1:0] mx);
        return up ? (c >= mx) : (c == 0);
    endfunction

    function automatic logic [W-1:0] next_val(logic [W-1:0] c, logic up, logic sat,
                                              logic [W-1:0] mx);
        if (up) return (c >= mx) ? (sat ? mx : 8'd0) : W'(c + 1);
        return (c == 0) ? (sat ? 8'd0 : mx) : W'(c - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_cnt[k] <= W'(rv[k]); m_tc[k] <= 1'b0; m_ovf[k] <= 1'b0; m_pre[k] <= 0;
            end else if (clr) begin
                m_cnt[k] <= '0; m_tc[k] <= 1'b0; m_ovf[k] <= 1'b0; m_pre[k] <= 0;
            end else if (load) begin
                m_cnt[k] <= load_val; m_tc[k] <= 1'b0; m_pre[k] <= 0;
            end else if (en && (m_pre[k] == ps[k] - 1)) begin
                m_pre[k] <= 0;
                m_cnt[k] <= next_val(m_cnt[k], dir, mode, max_val);
                m_tc[k]  <= at_bound(m_cnt[k], dir, max_val);
                if (at_bound(m_cnt[k], dir, max_val)) m_ovf[k] <= 1'b1;
            end else begin
                if (en) m_pre[k] <= m_pre[k] + 1;
                m_tc[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_a_count", 32'(cnt_a), 32'(m_cnt[0]));
            chk("model_a_tc",    32'(tc_a),  32'(m_tc[0]));
            chk("model_a_ovf",   32'(ovf_a), 32'(m_ovf[0]));
            chk("model_b_count", 32'(cnt_b), 32'(m_cnt[1]));
            chk("model_b_tc",    32'(tc_b),  32'(m_tc[1]));
            chk("model_b_ovf",   32'(ovf_b), 32'(m_ovf[1]));
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; clr = 0; load = 0;
    endtask

    initial begin
        logic [W-1:0] up_seq [7];
        logic [W-1:0] dn_seq [4];
        logic         dn_tc  [4];
        logic [W-1:0] pb_seq [6];
        logic         pb_en  [6];
        up_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
        dn_seq = '{8'd1, 8'd0, 8'd0, 8'd0};
        dn_tc  = '{1'b0, 1'b0, 1'b1, 1'b1};
        pb_en  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pb_seq = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};

        rst_n = 0; idle(); load_val = '0; dir = 1; mode = 0; max_val = 8'd5;
        #12;
        chk("reset_a_count", 32'(cnt_a), 32'd3);
        chk("reset_a_tc",    32'(tc_a),  32'd0);
        chk("reset_a_ovf",   32'(ovf_a), 32'd0);
        chk("reset_b_count", 32'(cnt_b), 32'd0);
        run_cmp = 1;
        rst_n = 1;
        edge1();

        // Wrap up to max_val=5
        clr = 1; edge1(); clr = 0;
        chk("clr_count", 32'(cnt_a), 32'd0);
        max_val = 8'd5; dir = 1; mode = 0; en = 1;
        for (int i = 0; i < 7; i++) begin
            edge1();
            chk("wrap_up_count", 32'(cnt_a), 32'(up_seq[i]));
            chk("wrap_up_tc",    32'(tc_a),  32'(up_seq[i] == 0));
        end
        chk("wrap_up_ovf", 32'(ovf_a), 32'd1);

        // Saturate down from a loaded 2
        idle(); clr = 1; edge1(); clr = 0;
        load = 1; load_val = 8'd2; edge1(); load = 0;
        chk("sat_load_count", 32'(cnt_a), 32'd2);
        chk("sat_load_ovf",   32'(ovf_a), 32'd0);
        dir = 0; mode = 1; en = 1;
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk("sat_dn_count", 32'(cnt_a), 32'(dn_seq[i]));
            chk("sat_dn_tc",    32'(tc_a),  32'(dn_tc[i]));
        end
        chk("sat_dn_ovf", 32'(ovf_a), 32'd1);

        // Priority: clr over load over step
        clr = 1; load = 1; load_val = 8'h55; en = 1; dir = 1; mode = 0; max_val = 8'hFF;
        edge1();
        chk("prio_clr_count", 32'(cnt_a), 32'd0);
        chk("prio_clr_ovf",   32'(ovf_a), 32'd0);
        chk("prio_clr_tc",    32'(tc_a),  32'd0);
        clr = 0; load = 1; load_val = 8'h7F;
        edge1();
        chk("prio_load_count", 32'(cnt_a), 32'h7F);
        chk("prio_load_b",     32'(cnt_b), 32'h7F);

        // Prescale-by-4 on instance b
        idle(); clr = 1; edge1(); clr = 0;
        max_val = 8'hFF; dir = 1; mode = 0; en = 1;
        for (int i = 1; i <= 8; i++) begin
            edge1();
            chk("psc_count", 32'(cnt_b), 32'(i / 4));
        end
        for (int i = 0; i < 6; i++) begin
            en = pb_en[i];
            edge1();
            chk("psc_freeze_count", 32'(cnt_b), 32'(pb_seq[i]));
            chk("psc_freeze_tc",    32'(tc_b),  32'd0);
        end

        // Boundary corner cases on instance a
        idle(); load = 1; load_val = 8'd10; max_val = 8'd5; dir = 1; mode = 0;
        edge1(); load = 0;
        chk("over_load_count", 32'(cnt_a), 32'd10);
        en = 1; edge1(); en = 0;
        chk("over_up_count", 32'(cnt_a), 32'd0);
        chk("over_up_tc",    32'(tc_a),  32'd1);
        load = 1; load_val = 8'hFF; max_val = 8'hFF; edge1(); load = 0;
        en = 1; edge1(); en = 0;
        chk("full_wrap_count", 32'(cnt_a), 32'd0);
        chk("full_wrap_tc",    32'(tc_a),  32'd1);
        load = 1; load_val = 8'd10; max_val = 8'd5; dir = 0; edge1(); load = 0;
        en = 1; edge1(); en = 0;
        chk("over_dn_count", 32'(cnt_a), 32'd9);
        chk("over_dn_tc",    32'(tc_a),  32'd0);
        edge1();
        chk("tc_drop", 32'(tc_a), 32'd0);

        // Asynchronous reset between edges
        load = 1; load_val = 8'h42; edge1(); load = 0;
        chk("pre_rst_count", 32'(cnt_a), 32'h42);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_count", 32'(cnt_a), 32'd3);
        chk("async_rst_tc",    32'(tc_a),  32'd0);
        chk("async_rst_ovf",   32'(ovf_a), 32'd0);
        chk("async_rst_b",     32'(cnt_b), 32'd0);
        edge1();
        chk("held_rst_count", 32'(cnt_a), 32'd3);
        #3;
        rst_n = 1;
        edge1();
        chk("post_rst_count", 32'(cnt_a), 32'd3);
        edge1();

        run_cmp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_param_counter
